// File: rtl/dequant_arb_pkg.sv
// dequant_arb_pkg: shared defaults and tag type for dequant_arbiter
package dequant_arb_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int PIPE_LAT_DEF = 5;
  localparam int DATA_W_DEF = 32;
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  localparam int ID_W = id_w(8);
  typedef struct packed {
    logic valid;
    logic [ID_W-1:0] id;
  } arb_tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant starting after the last granted index
// ports: clk, rst, req[N], advance (grant may be taken) -> one-hot gnt, gnt_idx
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N-1:0]                req,
  input  logic                        advance,
  output logic [N-1:0]                gnt,
  output logic [(N<2?1:$clog2(N))-1:0] gnt_idx
);
  localparam int PW = (N < 2) ? 1 : $clog2(N);
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_cand;
  logic          w_found;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_cand = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % N);
      if (!w_found && req[w_cand]) begin
        gnt[w_cand] = 1'b1;
        gnt_idx = w_cand;
        w_found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= PW'(N - 1);
    else if (advance && w_found) r_ptr <= gnt_idx;
  end
endmodule

// File: rtl/dequant_arbiter.sv
// dequant_arbiter: round-robin sharing of one pipelined dequantizer between NUM_REQ requesters
// ports: req_* (valid/ready/level/is_weight), rsp_* (valid/data), dq_* to/from dequantizer, hold, busy
// DEQ_ARB_PERF_CNT_EN adds saturating perf_grant_cnt / perf_stall_cnt outputs
module dequant_arbiter
  import dequant_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            hold,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_level,
  input  logic [NUM_REQ-1:0]              req_is_weight,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [NUM_REQ-1:0][DATA_W-1:0]  rsp_data,
  output logic [DATA_W-1:0]               dq_level_int,
  output logic                            dq_is_weight,
  input  logic [DATA_W-1:0]               dq_weight_fp,
  output logic                            busy
`ifdef DEQ_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ-1:0][31:0]        perf_grant_cnt,
  output logic [31:0]                     perf_stall_cnt
`endif
);
  localparam int PW = id_w(NUM_REQ);
  logic [NUM_REQ-1:0]  w_gnt;
  logic [PW-1:0]       w_gnt_idx;
  logic                w_hs;
  logic                w_pipe_busy;
  arb_tag_t            r_issue;
  arb_tag_t            r_pipe [PIPE_LAT];
  arb_tag_t            w_tail;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (!hold),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );
  assign req_ready = hold ? '0 : w_gnt;
  assign w_hs = |req_ready;
  assign w_tail = r_pipe[PIPE_LAT-1];
  always_comb begin
    w_pipe_busy = 1'b0;
    for (int k = 0; k < PIPE_LAT; k++) w_pipe_busy = w_pipe_busy | r_pipe[k].valid;
  end
  assign busy = r_issue.valid | w_pipe_busy | (|rsp_valid);
  always_ff @(posedge clk) begin
    if (rst) begin
      dq_level_int <= '0;
      dq_is_weight <= 1'b0;
      r_issue <= '0;
      for (int k = 0; k < PIPE_LAT; k++) r_pipe[k] <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
    end else begin
      dq_level_int <= w_hs ? req_level[w_gnt_idx] : '0;
      dq_is_weight <= w_hs & req_is_weight[w_gnt_idx];
      r_issue <= {w_hs, w_hs ? ID_W'(w_gnt_idx) : ID_W'(0)};
      r_pipe[0] <= r_issue;
      for (int k = 1; k < PIPE_LAT; k++) r_pipe[k] <= r_pipe[k-1];
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_valid[i] <= w_tail.valid && (w_tail.id == ID_W'(i));
        if (w_tail.valid && (w_tail.id == ID_W'(i))) rsp_data[i] <= dq_weight_fp;
      end
    end
  end
`ifdef DEQ_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ready[i] && perf_grant_cnt[i] != '1) perf_grant_cnt[i] <= perf_grant_cnt[i] + 32'd1;
      if (|req_valid && !w_hs && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dequant_arbiter.sv
// tb_dequant_arbiter: randomized and directed checks of dequant_arbiter against a scoreboard model
module tb_dequant_arbiter;
  localparam int N = 4, L = 5, W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1, hold = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, req_is_weight = '0, rsp_valid;
  logic [N-1:0][W-1:0] req_level = '0, rsp_data;
  logic [W-1:0] dq_level_int, dq_weight_fp;
  logic dq_is_weight, busy;
`ifdef DEQ_ARB_PERF_CNT_EN
  logic [N-1:0][31:0] perf_grant_cnt;
  logic [31:0] perf_stall_cnt;
`endif
  always #5 clk = ~clk;
  dequant_arbiter #(.NUM_REQ(N), .PIPE_LAT(L), .DATA_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .hold          (hold),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_level     (req_level),
    .req_is_weight (req_is_weight),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .dq_level_int  (dq_level_int),
    .dq_is_weight  (dq_is_weight),
    .dq_weight_fp  (dq_weight_fp),
    .busy          (busy)
`ifdef DEQ_ARB_PERF_CNT_EN
    ,
    .perf_grant_cnt(perf_grant_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );
  function automatic logic [31:0] deq(input logic [31:0] lv, input logic w);
    return w ? (lv * 32'd3 + 32'h3f80_0000) : (lv ^ 32'h4000_0000);
  endfunction
  logic [W-1:0] dq_pipe [L];
  always @(posedge clk) begin
    dq_pipe[0] <= deq(dq_level_int, dq_is_weight);
    for (int k = 1; k < L; k++) dq_pipe[k] <= dq_pipe[k-1];
  end
  assign dq_weight_fp = dq_pipe[L-1];
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  typedef struct { int due; int lane; logic [31:0] data; } rsp_t;
  rsp_t q[$];
  int last = N - 1;
  int cyc = 0;
  int fix_lane = -1;
  logic [31:0] fix_level = '0;
  logic [N-1:0] pend = '0;
  logic [N-1:0][W-1:0] m_data = '0;
  logic [W-1:0] m_dq_lvl = '0;
  logic m_dq_w = 1'b0;
  int m_gcnt[N] = '{default: 0};
  int m_stall = 0;
  task automatic step(input logic [N-1:0] v, input logic h, input logic r);
    logic [N-1:0] er, ev;
    int g;
    @(posedge clk);
    #1;
    rst = r;
    hold = h;
    for (int i = 0; i < N; i++) begin
      if (v[i] && !r) begin
        if (!pend[i]) begin
          req_level[i] = (fix_lane == i) ? fix_level : $urandom;
          req_is_weight[i] = (fix_lane == i) ? 1'b1 : 1'($urandom);
        end
        req_valid[i] = 1'b1;
      end else req_valid[i] = 1'b0;
    end
    fix_lane = -1;
    @(negedge clk);
    g = -1;
    if (!h && !r)
      for (int k = 1; k <= N; k++)
        if (g < 0 && req_valid[(last + k) % N]) g = (last + k) % N;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", req_ready, er);
    check("busy", busy, q.size() != 0);
    check("dq_level_int", dq_level_int, m_dq_lvl);
    check("dq_is_weight", dq_is_weight, m_dq_w);
    ev = '0;
    if (q.size() != 0 && q[0].due == cyc) begin
      ev[q[0].lane] = 1'b1;
      m_data[q[0].lane] = q[0].data;
      void'(q.pop_front());
    end
    check("rsp_valid", rsp_valid, ev);
    check("rsp_data", rsp_data, m_data);
`ifdef DEQ_ARB_PERF_CNT_EN
    begin
      logic [N-1:0][31:0] eg;
      for (int i = 0; i < N; i++) eg[i] = m_gcnt[i];
      check("perf_grant_cnt", perf_grant_cnt, eg);
      check("perf_stall_cnt", perf_stall_cnt, m_stall);
    end
`endif
    if (r) begin
      q.delete();
      last = N - 1;
      m_data = '0;
      m_dq_lvl = '0;
      m_dq_w = 1'b0;
      m_gcnt = '{default: 0};
      m_stall = 0;
      pend = '0;
    end else begin
      if (|req_valid && g < 0) m_stall++;
      if (g >= 0) begin
        q.push_back('{due: cyc + 2 + L, lane: g, data: deq(req_level[g], req_is_weight[g])});
        m_dq_lvl = req_level[g];
        m_dq_w = req_is_weight[g];
        last = g;
        m_gcnt[g]++;
      end else begin
        m_dq_lvl = '0;
        m_dq_w = 1'b0;
      end
      pend = req_valid & ~er;
    end
    cyc++;
  endtask
  initial begin
    repeat (2) step('0, 1'b0, 1'b1);
    repeat (20) step('0, 1'b0, 1'b0);
    fix_lane = 2;
    fix_level = 32'h11;
    step(4'b0100, 1'b0, 1'b0);
    repeat (10) step('0, 1'b0, 1'b0);
    repeat (12) step(4'hF, 1'b0, 1'b0);
    repeat (9) step('0, 1'b0, 1'b0);
    repeat (3) step(4'b1010, 1'b0, 1'b0);
    repeat (4) step(4'b1010, 1'b1, 1'b0);
    repeat (4) step(4'b1010, 1'b0, 1'b0);
    repeat (9) step('0, 1'b0, 1'b0);
    repeat (4) step(4'hF, 1'b0, 1'b0);
    repeat (2) step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    step(4'hF, 1'b0, 1'b0);
    repeat (10) step('0, 1'b0, 1'b0);
    repeat (600) step(N'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 80) == 0);
    repeat (10) step('0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dequant_arbiter.md
# dequant_arbiter

Round-robin scheduler sharing one fully pipelined `dequantizer_block` between `NUM_REQ` requesters. Each accepted request is registered onto the dequantizer input. A tag pipeline aligned to the dequantizer latency routes each FP32 result back to the requester that issued it. Throughput is one request per cycle across all requesters. The arbiter sits between the per-lane weight/activation fetch units and the single dequantizer instance.

## Interface
- `NUM_REQ`, 4 — number of requesters (2..8).
- `PIPE_LAT`, 5 — dequantizer latency in cycles, from input presented to `weight_fp_reg` valid.
- `DATA_W`, 32 — width of level and result words.
- `clk` in 1 — single clock; all logic on its rising edge.
- `rst` in 1 — reset, synchronous, active-high.
- `hold` in 1 — when high, no new grants are issued; in-flight results still drain.
- `req_valid` in [NUM_REQ] — request present.
- `req_ready` out [NUM_REQ] — request accepted this cycle.
- `req_level` in [NUM_REQ][DATA_W] — quantized level.
- `req_is_weight` in [NUM_REQ] — weight/activation select.
- `rsp_valid` out [NUM_REQ] — result valid for one cycle; no backpressure.
- `rsp_data` out [NUM_REQ][DATA_W] — FP32 result.
- `dq_level_int` out DATA_W — to `dequantizer_block.level_int`.
- `dq_is_weight` out 1 — to `dequantizer_block.is_weight`.
- `dq_weight_fp` in DATA_W — from `dequantizer_block.weight_fp_reg`.
- `busy` out 1 — any request issued or in flight.

## Operation
- Grant logic:
  - `req_ready[i]` is high for at most one i per cycle.
  - `req_ready[i] = !hold & req_valid[i] & (i is the first valid requester after ptr, circularly)`.
  - `req_ready` may depend on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
  - Requesters hold `req_level` and `req_is_weight` stable while `req_valid & !req_ready`.
- Pointer:
  - `ptr` is `$clog2(NUM_REQ)` bits and updates to the granted index on every handshake.
  - With no handshake, `ptr` holds.
  - Reset value is `NUM_REQ-1`, so requester 0 has priority first.
- Issue register:
  - On a handshake, `dq_level_int` and `dq_is_weight` load the granted requester's data. The issue tag loads {valid=1, id}.
  - With no handshake, both outputs load 0 and the tag loads valid=0. Idle inputs to the dequantizer are therefore all-zero.
- Tag pipeline:
  - `PIPE_LAT`-deep shift register of {valid, id[$clog2(NUM_REQ)]}, fed from the issue tag.
  - The tail entry aligns with `dq_weight_fp`.
- Response register:
  - Each cycle, `rsp_valid[tail.id]` is set to `tail.valid`. All other `rsp_valid` bits are 0.
  - `rsp_data[tail.id]` loads `dq_weight_fp` when `tail.valid`. Other lanes hold their previous data.
- `busy` = issue tag valid OR any tag-pipe valid OR any `rsp_valid`.
- `hold` blocks only new grants. It does not freeze the pipeline, and the pointer holds while it is high.
- Reset, including mid-operation:
  - All registers clear. Outputs are 0 in the cycle after the reset edge.
  - In-flight tags are discarded, so results still exiting the dequantizer are dropped.
  - The first grant can occur in the first cycle with `rst` low.

## Timing
- Handshake in cycle c:
  - `dq_level_int` and `dq_is_weight` present in cycle c+1.
  - `dq_weight_fp` valid in cycle c+1+PIPE_LAT.
  - `rsp_valid` in cycle c+2+PIPE_LAT (7 cycles for the default configuration).
- Back-to-back grants in consecutive cycles are allowed. Sustained throughput is 1 result per cycle.
- Results leave the block in issue order across all requesters.
- Simultaneous events are legal and independent: a handshake and a response to the same requester in the same cycle.
- `req_ready` is combinational from `req_valid`, `hold` and `ptr`. All other outputs are registered.

## Configuration
- `DEQ_ARB_PERF_CNT_EN` defined:
  - Adds output `perf_grant_cnt [NUM_REQ][32]`, a per-requester handshake count.
  - Adds output `perf_stall_cnt [32]`, which counts cycles where any `req_valid` is high but no grant occurs (hold or arbitration loss with no grant).
  - Both counters saturate at all-ones and clear on `rst`.
- Not defined: the counters and their ports are absent. Functional behaviour is identical.

## Structure
- Package `dequant_arb_pkg`:
  - Defaults `NUM_REQ_DEF`, `PIPE_LAT_DEF`, `DATA_W_DEF`.
  - Typedef `arb_tag_t` {logic valid; logic [ID_W-1:0] id}, and the `ID_W` function/constant.
- Sub-module `rr_arbiter`:
  - Parameterized by N.
  - Inputs `req`, `advance`. Outputs one-hot `gnt` and `gnt_idx`.
  - Owns `ptr`.
  - Instantiated once. Tag pipe and response routing live in the top.

## Test plan
- Single request: lane 2 issues level=0x11, is_weight=1 in cycle 10, with a reference-model dequantizer → `dq_level_int`=0x11 in cycle 11; `rsp_valid[2]` only in cycle 17 with the model's FP32 value.
- All four valid continuously for 12 cycles → grant order 0,1,2,3,0,1,… (3 grants each); 12 responses in the same order, exactly 7 cycles after each grant.
- Lanes 1 and 3 valid, `hold` high in cycles 5–8 → no `req_ready` in 5–8; pointer unchanged; grants resume with the lane after the last grant; responses issued before cycle 5 still arrive.
- `rst` pulsed 3 cycles after a burst of 4 grants → all `rsp_valid` stay 0 afterwards; `busy`=0 the cycle after reset; the next grant goes to lane 0.
- Idle check: no requests for 20 cycles → `dq_level_int`=0, `dq_is_weight`=0, `busy`=0 throughout.
- With `DEQ_ARB_PERF_CNT_EN`: the 12-cycle all-valid run gives `perf_grant_cnt`={3,3,3,3}; 4 hold cycles with lanes valid add 4 to `perf_stall_cnt`.
